spi_controller: RTL and testbench

- Synthesizable SPI main (mode 0: CPOL=0, CPHA=0) that sequences byte transfers to a single SPI subunit.
- Drives SCLK, MOSI and CS, and samples MISO.
- Provides a start/busy/done byte handshake to the host logic.
- Supports back-to-back multi-byte transactions with CS held low (hold_cs).

---
 rtl/spi_controller.sv | 90 +++++++++
 tb/tb_spi_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 byte master with start/busy/done handshake and CS hold between bytes
module spi_controller #(
  parameter int CLK_FREQUENCY  = 100_000_000,
  parameter int SCLK_FREQUENCY = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_to_send,
  input  logic       hold_cs,
  output logic [7:0] data_received,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);
  localparam int HALF_PERIOD = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int CW = $clog2(HALF_PERIOD < 2 ? 2 : HALF_PERIOD);
  localparam logic [2:0] IDLE = 3'd0, LOW = 3'd1, HIGH = 3'd2, WAIT = 3'd3, CS_TAIL = 3'd4, CS_GAP = 3'd5;
  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $fatal(1, "spi_controller: HALF_PERIOD must be >= 2");
  end
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift, rx_shift;
  logic timed, expire, load;
  assign timed = state == LOW || state == HIGH || state == CS_TAIL || state == CS_GAP;
  assign expire = timed && cnt == CW'(HALF_PERIOD - 1);
  assign load = start && (state == IDLE || state == WAIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      data_received <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs <= 1'b1;
    end else begin
      done <= 1'b0;
      cnt <= timed && !expire ? cnt + 1'b1 : '0;
      if (load) begin
        tx_shift <= data_to_send;
        spi_mosi <= data_to_send[7];
        spi_cs <= 1'b0;
        bit_cnt <= '0;
        busy <= 1'b1;
        state <= LOW;
      end else if (expire) begin
        case (state)
          LOW: begin
            spi_sclk <= 1'b1;
            rx_shift <= {rx_shift[6:0], spi_miso};
            state <= HIGH;
          end
          HIGH: begin
            spi_sclk <= 1'b0;
            if (bit_cnt != 3'd7) begin
              tx_shift <= tx_shift << 1;
              spi_mosi <= tx_shift[6];
              bit_cnt <= bit_cnt + 1'b1;
              state <= LOW;
            end else begin
              data_received <= rx_shift;
              done <= 1'b1;
              state <= hold_cs ? WAIT : CS_TAIL;
            end
          end
          CS_TAIL: begin
            spi_cs <= 1'b1;
            state <= CS_GAP;
          end
          default: begin
            busy <= 1'b0;
            state <= IDLE;
          end
        endcase
      end else if (state == WAIT && !hold_cs) begin
        state <= CS_TAIL;
      end
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: scoreboard bench for spi_controller at H=5 and H=2 with a mode-0 subunit model
module tb_spi_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold_cs = 1'b0, sel = 1'b0, loop = 1'b1;
  logic [7:0] data_to_send = 8'h00;
  logic [7:0] rx5, rx2, rx;
  logic busy5, busy2, done5, done2, sclk5, sclk2, mosi5, mosi2, cs5, cs2;
  logic busy, done, sclk, mosi, cs, miso;
  logic s_bit = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int cs_low = 0, cs_rises = 0, dones = 0, mosi_viol = 0, rises = 0, per_bad = 0, last_rise = 0;
  logic cs_q = 1'b1, sclk_q = 1'b0, mosi_q = 1'b0;
  logic [7:0] cap = 8'h00, s_reg = 8'h00;
  logic [2:0] s_pos = 3'd7;
  int s0, s1, b_low, b_rises, b_dones;
  typedef struct { logic [7:0] rx; logic [7:0] tx; int at; } exp_t;
  typedef struct { int at; int id; int ex; string nm; } probe_t;
  exp_t sb[$];
  probe_t pq[$];
  logic [7:0] miso_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rx = sel ? rx2 : rx5;
  assign busy = sel ? busy2 : busy5;
  assign done = sel ? done2 : done5;
  assign sclk = sel ? sclk2 : sclk5;
  assign mosi = sel ? mosi2 : mosi5;
  assign cs = sel ? cs2 : cs5;
  assign miso = loop ? mosi : s_bit;
  spi_controller dut5 (
    .clk(clk), .rst(rst), .start(start && !sel), .data_to_send(data_to_send), .hold_cs(hold_cs),
    .data_received(rx5), .busy(busy5), .done(done5), .spi_sclk(sclk5), .spi_mosi(mosi5),
    .spi_miso(miso), .spi_cs(cs5)
  );
  spi_controller #(.SCLK_FREQUENCY(25_000_000)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel), .data_to_send(data_to_send), .hold_cs(hold_cs),
    .data_received(rx2), .busy(busy2), .done(done2), .spi_sclk(sclk2), .spi_mosi(mosi2),
    .spi_miso(miso), .spi_cs(cs2)
  );
  task automatic chk(input string nm, input int got, input int ex);
    checks++;
    if (got != ex) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, ex);
    end
  endtask
  function automatic int pval(input int id);
    case (id)
      0: return int'(cs);
      1: return int'(sclk);
      2: return int'(busy);
      3: return int'(done);
      4: return int'(rx);
      5: return cs_low;
      6: return cs_rises;
      7: return dones;
      8: return mosi_viol;
      9: return sb.size();
      default: return -1;
    endcase
  endfunction
  always @(negedge clk) begin
    exp_t e;
    probe_t p;
    if (!cs) cs_low++;
    if (cs && !cs_q) cs_rises++;
    if (!cs && cs_q) begin
      cap = 8'h00;
      rises = 0;
      per_bad = 0;
      s_reg = miso_q.size() > 0 ? miso_q.pop_front() : 8'h00;
      s_pos = 3'd7;
    end
    if (sclk && !sclk_q) begin
      cap = {cap[6:0], mosi};
      rises++;
      if (rises > 1 && cyc - last_rise != (sel ? 4 : 10)) per_bad++;
      last_rise = cyc;
    end
    if (!sclk && sclk_q && !cs) begin
      s_pos = s_pos - 3'd1;
      if (s_pos == 3'd7) s_reg = miso_q.size() > 0 ? miso_q.pop_front() : 8'h00;
    end
    if (sclk && sclk_q && mosi != mosi_q) mosi_viol++;
    s_bit = s_reg[s_pos];
    if (done) begin
      dones++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("data_received", int'(rx), int'(e.rx));
        chk("mosi_byte", int'(cap), int'(e.tx));
        chk("done_cycle", cyc, e.at);
        chk("sclk_rises", rises, 8);
        chk("sclk_period_errs", per_bad, 0);
      end
      rises = 0;
      per_bad = 0;
      cap = 8'h00;
    end
    while (pq.size() > 0 && pq[0].at <= cyc) begin
      p = pq.pop_front();
      chk(p.nm, pval(p.id), p.ex);
    end
    cs_q = cs;
    sclk_q = sclk;
    mosi_q = mosi;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask
  task automatic probe(input int at, input string nm, input int id, input int ex);
    pq.push_back('{at, id, ex, nm});
  endtask
  task automatic expect_byte(input logic [7:0] r, input logic [7:0] t, input int at);
    sb.push_back('{r, t, at});
  endtask
  task automatic send(input logic [7:0] d, input logic h);
    tick();
    start = 1'b1;
    data_to_send = d;
    hold_cs = h;
    s0 = cyc + 1;
    b_low = cs_low;
    b_rises = cs_rises;
    b_dones = dones;
    tick();
    start = 1'b0;
    data_to_send = ~d;
  endtask
  initial begin
    repeat (3) tick();
    probe(cyc + 1, "rst_cs", 0, 1);
    probe(cyc + 1, "rst_sclk", 1, 0);
    probe(cyc + 1, "rst_busy", 2, 0);
    probe(cyc + 1, "rst_done", 3, 0);
    probe(cyc + 1, "rst_rx", 4, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    loop = 1'b1;
    send(8'hA5, 1'b0);
    expect_byte(8'hA5, 8'hA5, s0 + 80);
    probe(s0 + 85, "t1_cs_high", 0, 1);
    probe(s0 + 85, "t1_cs_low_cycles", 5, b_low + 85);
    probe(s0 + 85, "t1_cs_rises", 6, b_rises + 1);
    probe(s0 + 89, "t1_busy_hi", 2, 1);
    probe(s0 + 90, "t1_busy_lo", 2, 0);
    probe(s0 + 95, "t1_done_count", 7, b_dones + 1);
    wait_to(s0 + 96);
    loop = 1'b0;
    miso_q.push_back(8'h3C);
    send(8'hFF, 1'b0);
    expect_byte(8'h3C, 8'hFF, s0 + 80);
    wait_to(s0 + 96);
    miso_q.push_back(8'h11);
    miso_q.push_back(8'h22);
    send(8'h01, 1'b1);
    expect_byte(8'h11, 8'h01, s0 + 80);
    wait_to(s0 + 80);
    start = 1'b1;
    data_to_send = 8'h02;
    s1 = cyc + 1;
    expect_byte(8'h22, 8'h02, s1 + 80);
    tick();
    start = 1'b0;
    hold_cs = 1'b0;
    data_to_send = 8'hEE;
    probe(s1 + 84, "t3_cs_still_low", 0, 0);
    probe(s1 + 85, "t3_cs_low_cycles", 5, b_low + 81 + 85);
    probe(s1 + 85, "t3_cs_rises", 6, b_rises + 1);
    probe(s1 + 95, "t3_done_count", 7, b_dones + 2);
    wait_to(s1 + 96);
    loop = 1'b1;
    send(8'hC3, 1'b0);
    expect_byte(8'hC3, 8'hC3, s0 + 80);
    wait_to(s0 + 1);
    start = 1'b1;
    data_to_send = 8'h3C;
    tick();
    start = 1'b0;
    wait_to(s0 + 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(s0 + 87);
    start = 1'b1;
    tick();
    start = 1'b0;
    probe(s0 + 100, "t4_done_count", 7, b_dones + 1);
    probe(s0 + 100, "t4_busy_idle", 2, 0);
    wait_to(s0 + 101);
    send(8'h96, 1'b0);
    wait_to(s0 + 45);
    rst = 1'b1;
    probe(s0 + 46, "t5_cs", 0, 1);
    probe(s0 + 46, "t5_sclk", 1, 0);
    probe(s0 + 46, "t5_busy", 2, 0);
    probe(s0 + 46, "t5_done", 3, 0);
    probe(s0 + 46, "t5_rx", 4, 0);
    probe(s0 + 60, "t5_no_done", 7, b_dones);
    tick();
    rst = 1'b0;
    wait_to(s0 + 61);
    send(8'h5A, 1'b0);
    expect_byte(8'h5A, 8'h5A, s0 + 80);
    wait_to(s0 + 96);
    sel = 1'b1;
    tick();
    send(8'h6B, 1'b0);
    expect_byte(8'h6B, 8'h6B, s0 + 32);
    probe(s0 + 33, "t6_cs_low", 0, 0);
    probe(s0 + 34, "t6_cs_high", 0, 1);
    probe(s0 + 35, "t6_busy_hi", 2, 1);
    probe(s0 + 36, "t6_busy_lo", 2, 0);
    wait_to(s0 + 40);
    send(8'h0F, 1'b0);
    expect_byte(8'h0F, 8'h0F, s0 + 32);
    wait_to(s0 + 40);
    probe(cyc + 1, "mosi_stable_high", 8, 0);
    probe(cyc + 1, "scoreboard_empty", 9, 0);
    for (int i = 0; i < 1000 && pq.size() > 0; i++) tick();
    if (pq.size() > 0) begin
      $display("FAIL probe_timeout: %0d probes pending", pq.size());
      $fatal(1, "probe queue did not drain");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
